// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a show-ahead FIFO into a
// two-entry skid buffer feeding a valid/ready stream.
module fifo_stream_reader #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_re,
    input  logic             flush,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       count,
    output logic [CNT_W-1:0] xfer_count
);

    // Occupancy doubles as the FSM state: the encoding is the word count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             push;
    logic             pop;
    logic             ld0_fifo;
    logic             ld0_skid;
    logic             ld1_fifo;

    // Read only when there is room; the decision uses registered
    // occupancy so m_ready never reaches the FIFO combinationally.
    assign fifo_re = !rst && !flush && !fifo_empty && (state != S_TWO);

    assign push    = fifo_re;
    assign m_valid = (state != S_EMPTY);
    assign pop     = m_valid && m_ready;
    assign count   = state;
    assign m_data  = slot0;

    // Occupancy register; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and slot load selects; slot0 always holds the oldest.
    always_comb begin
        state_nxt = state;
        ld0_fifo  = 1'b0;
        ld0_skid  = 1'b0;
        ld1_fifo  = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        ld0_fifo  = 1'b1;
                        state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        ld0_fifo = 1'b1;
                    end else if (push) begin
                        ld1_fifo  = 1'b1;
                        state_nxt = S_TWO;
                    end else if (pop) begin
                        state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        ld0_skid  = 1'b1;
                        state_nxt = S_ONE;
                    end
                end
                default: begin
                    state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // Data slots; the head slot shifts from the skid slot on a pop at two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (ld0_fifo) begin
                slot0 <= fifo_data;
            end else if (ld0_skid) begin
                slot0 <= slot1;
            end
            if (ld1_fifo) begin
                slot1 <= fifo_data;
            end
        end
    end

    // Completed downstream transfers; flush does not suppress a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

endmodule
